// File: rtl/dsp_write_router_if.sv
// ----------------------------------------------------------------------------
// dsp_write_router_if
// Bundles the host write stream, burst control and memory write ports of
// dsp_write_router.
//   slave  : router side (consumes host stream, drives memory writes)
//   master : host / environment side
// Signals:
//   wr_valid/wr_ready/wr_addr/wr_data  host write beat handshake
//   burst_start/burst_addr/burst_len   burst request, burst_done completion
//   cmd_lock                           command memories busy, stall cmd beats
//   cmd_we/cmd_waddr/cmd_wdata         command slice write port
//   env_we/env_waddr/env_wdata         element envelope write port
//   addr_err                           sticky dropped-beat flag
//   err_count                          only with DSP_WRITE_ROUTER_ERRCNT_EN
// ----------------------------------------------------------------------------
interface dsp_write_router_if #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int CMD_ADDR_WIDTH  = 8,
  parameter int MEM_TO_CMD      = 4,
  parameter int N_ELEM          = 3,
  parameter int ENV_ADDR_WIDTH  = 12,
  parameter int BURST_LEN_WIDTH = 12
);
  logic                       wr_valid;
  logic                       wr_ready;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       burst_start;
  logic [ADDR_WIDTH-1:0]      burst_addr;
  logic [BURST_LEN_WIDTH-1:0] burst_len;
  logic                       burst_done;
  logic                       cmd_lock;
  logic [MEM_TO_CMD-1:0]      cmd_we;
  logic [CMD_ADDR_WIDTH-1:0]  cmd_waddr;
  logic [DATA_WIDTH-1:0]      cmd_wdata;
  logic [N_ELEM-1:0]          env_we;
  logic [ENV_ADDR_WIDTH-1:0]  env_waddr;
  logic [DATA_WIDTH-1:0]      env_wdata;
  logic                       addr_err;
`ifdef DSP_WRITE_ROUTER_ERRCNT_EN
  logic [15:0]                err_count;
`endif

  modport slave (
`ifdef DSP_WRITE_ROUTER_ERRCNT_EN
    output err_count,
`endif
    input  wr_valid, wr_addr, wr_data, burst_start, burst_addr, burst_len, cmd_lock,
    output wr_ready, burst_done, cmd_we, cmd_waddr, cmd_wdata,
    output env_we, env_waddr, env_wdata, addr_err
  );

  modport master (
`ifdef DSP_WRITE_ROUTER_ERRCNT_EN
    input  err_count,
`endif
    output wr_valid, wr_addr, wr_data, burst_start, burst_addr, burst_len, cmd_lock,
    input  wr_ready, burst_done, cmd_we, cmd_waddr, cmd_wdata,
    input  env_we, env_waddr, env_wdata, addr_err
  );
endinterface

// File: rtl/dsp_write_router.sv
// ----------------------------------------------------------------------------
// dsp_write_router
// Host-write front end for a multi-element DSP unit. Each accepted beat
// (single or auto-incrementing burst) is decoded into one command memory
// slice or one element envelope memory and issued one cycle later from a
// registered output stage. Command-space beats stall while cmd_lock is high;
// beats to reserved/out-of-range addresses are accepted, dropped and flagged.
// Ports:
//   i_clk    clock
//   i_reset  asynchronous, active-low reset
//   io_wr    dsp_write_router_if.slave (write stream, burst, memory ports)
// Optional feature macro: DSP_WRITE_ROUTER_ERRCNT_EN adds a saturating 16-bit
// err_count of dropped beats and ignored burst_start pulses.
// ----------------------------------------------------------------------------
module dsp_write_router #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int CMD_ADDR_WIDTH  = 8,
  parameter int MEM_TO_CMD      = 4,
  parameter int N_ELEM          = 3,
  parameter int ENV_ADDR_WIDTH  = 12,
  parameter int BURST_LEN_WIDTH = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  dsp_write_router_if.slave io_wr
);

  localparam int SLW   = $clog2(MEM_TO_CMD);
  localparam int SLW_I = (SLW > 0) ? SLW : 1;
  // Bits strictly below the space select that must be zero in each space.
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = {1'b0, {(ADDR_WIDTH-1){1'b1}}};
  localparam logic [ADDR_WIDTH-1:0] CMD_RSV  = LOW_MASK & ({ADDR_WIDTH{1'b1}} << (CMD_ADDR_WIDTH + SLW));
  localparam logic [ADDR_WIDTH-1:0] ENV_RSV  = LOW_MASK & ({ADDR_WIDTH{1'b1}} << (ENV_ADDR_WIDTH + 2));

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t                     r_state;
  logic [ADDR_WIDTH-1:0]      r_ptr;
  logic [BURST_LEN_WIDTH-1:0] r_rem;
  logic [MEM_TO_CMD-1:0]      r_cmd_we_p1;
  logic [CMD_ADDR_WIDTH-1:0]  r_cmd_waddr_p1;
  logic [DATA_WIDTH-1:0]      r_cmd_wdata_p1;
  logic [N_ELEM-1:0]          r_env_we_p1;
  logic [ENV_ADDR_WIDTH-1:0]  r_env_waddr_p1;
  logic [DATA_WIDTH-1:0]      r_env_wdata_p1;
  logic                       r_done_p1;
  logic                       r_addr_err;

  logic [ADDR_WIDTH-1:0]      w_addr;
  logic                       w_is_cmd;
  logic [SLW_I-1:0]           w_slice;
  logic [1:0]                 w_elem;
  logic [MEM_TO_CMD-1:0]      w_cmd_oh;
  logic [N_ELEM-1:0]          w_env_oh;
  logic                       w_ok;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_drop;
  logic                       w_ign;

  // Decode stage (combinational, current address)
  assign w_addr   = (r_state == BURST) ? r_ptr : io_wr.wr_addr;
  assign w_is_cmd = ~w_addr[ADDR_WIDTH-1];
  assign w_slice  = SLW_I'(w_addr >> CMD_ADDR_WIDTH) & SLW_I'(MEM_TO_CMD - 1);
  assign w_elem   = 2'(w_addr >> ENV_ADDR_WIDTH);
  assign w_cmd_oh = MEM_TO_CMD'(1) << w_slice;
  assign w_env_oh = N_ELEM'(1) << w_elem;
  assign w_ok     = w_is_cmd ? ((w_addr & CMD_RSV) == '0)
                             : (((w_addr & ENV_RSV) == '0) && (int'(w_elem) < N_ELEM));

  // A locked command space stalls the beat; invalid beats are still taken.
  assign w_ready  = i_reset & ~((r_state == IDLE) & io_wr.burst_start)
                            & ~(w_is_cmd & io_wr.cmd_lock);
  assign w_accept = io_wr.wr_valid & w_ready;
  assign w_drop   = w_accept & ~w_ok;
  assign w_ign    = (r_state == BURST) & io_wr.burst_start;

  // Output stage p1 and burst FSM
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_rem          <= '0;
      r_cmd_we_p1    <= '0;
      r_cmd_waddr_p1 <= '0;
      r_cmd_wdata_p1 <= '0;
      r_env_we_p1    <= '0;
      r_env_waddr_p1 <= '0;
      r_env_wdata_p1 <= '0;
      r_done_p1      <= 1'b0;
      r_addr_err     <= 1'b0;
    end else begin
      r_cmd_we_p1 <= '0;
      r_env_we_p1 <= '0;
      r_done_p1   <= 1'b0;
      if (w_accept && w_ok) begin
        if (w_is_cmd) begin
          r_cmd_we_p1    <= w_cmd_oh;
          r_cmd_waddr_p1 <= w_addr[CMD_ADDR_WIDTH-1:0];
          r_cmd_wdata_p1 <= io_wr.wr_data;
        end else begin
          r_env_we_p1    <= w_env_oh;
          r_env_waddr_p1 <= w_addr[ENV_ADDR_WIDTH-1:0];
          r_env_wdata_p1 <= io_wr.wr_data;
        end
      end
      if (w_drop || w_ign) r_addr_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (io_wr.burst_start) begin
            if (io_wr.burst_len == '0) begin
              r_done_p1 <= 1'b1;
            end else begin
              r_ptr   <= io_wr.burst_addr;
              r_rem   <= io_wr.burst_len;
              r_state <= BURST;
            end
          end
        end
        BURST: begin
          // Dropped beats still consume a burst slot.
          if (w_accept) begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
            r_rem <= r_rem - BURST_LEN_WIDTH'(1);
            if (r_rem == BURST_LEN_WIDTH'(1)) begin
              r_done_p1 <= 1'b1;
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DSP_WRITE_ROUTER_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_err_cnt <= '0;
    else          r_err_cnt <= sat_add16(r_err_cnt, {1'b0, w_drop} + {1'b0, w_ign});
  end

  assign io_wr.err_count = r_err_cnt;
`endif

  assign io_wr.wr_ready   = w_ready;
  assign io_wr.burst_done = r_done_p1;
  assign io_wr.cmd_we     = r_cmd_we_p1;
  assign io_wr.cmd_waddr  = r_cmd_waddr_p1;
  assign io_wr.cmd_wdata  = r_cmd_wdata_p1;
  assign io_wr.env_we     = r_env_we_p1;
  assign io_wr.env_waddr  = r_env_waddr_p1;
  assign io_wr.env_wdata  = r_env_wdata_p1;
  assign io_wr.addr_err   = r_addr_err;

endmodule

// File: tb/tb_dsp_write_router.sv
// ----------------------------------------------------------------------------
// tb_dsp_write_router
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model that tracks the router from its address map and burst
// rules using plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_dsp_write_router;
  localparam int AW = 16, DW = 32, CAW = 8, M = 4, NE = 3, EAW = 12, BLW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_write_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_ADDR_WIDTH(CAW),
    .MEM_TO_CMD(M), .N_ELEM(NE), .ENV_ADDR_WIDTH(EAW), .BURST_LEN_WIDTH(BLW)) bus ();

  dsp_write_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_ADDR_WIDTH(CAW),
    .MEM_TO_CMD(M), .N_ELEM(NE), .ENV_ADDR_WIDTH(EAW), .BURST_LEN_WIDTH(BLW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_wr   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model state
  bit          m_burst;
  int          m_ptr, m_rem;
  logic [3:0]  e_cmd_we;
  int          e_cmd_waddr;
  logic [31:0] e_cmd_wdata;
  logic [2:0]  e_env_we;
  int          e_env_waddr;
  logic [31:0] e_env_wdata;
  bit          e_done, e_err;
  int          e_cnt;

  task automatic model_reset();
    m_burst = 0; m_ptr = 0; m_rem = 0;
    e_cmd_we = '0; e_cmd_waddr = 0; e_cmd_wdata = '0;
    e_env_we = '0; e_env_waddr = 0; e_env_wdata = '0;
    e_done = 0; e_err = 0; e_cnt = 0;
  endtask

  // Address map: 0x0000-0x03FF cmd (4 slices x 256), 0x8000-0xAFFF env (3 x 4096).
  function automatic void decode(input int a, output bit is_cmd, output bit ok,
                                 output int idx, output int off);
    is_cmd = (a < 32768);
    if (is_cmd) begin
      idx = (a / 256) % 4;
      off = a % 256;
      ok  = ((a / 1024) % 32) == 0;
    end else begin
      idx = (a / 4096) % 4;
      off = a % 4096;
      ok  = (idx < 3) && (((a / 16384) % 2) == 0);
    end
  endfunction

  task automatic drive_idle();
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.burst_start = 0; bus.burst_addr = '0; bus.burst_len = '0; bus.cmd_lock = 0;
  endtask

  task automatic check_outputs();
    check("cmd_we",     32'(bus.cmd_we),     32'(e_cmd_we));
    check("cmd_waddr",  32'(bus.cmd_waddr),  e_cmd_waddr);
    check("cmd_wdata",  bus.cmd_wdata,       e_cmd_wdata);
    check("env_we",     32'(bus.env_we),     32'(e_env_we));
    check("env_waddr",  32'(bus.env_waddr),  e_env_waddr);
    check("env_wdata",  bus.env_wdata,       e_env_wdata);
    check("burst_done", 32'(bus.burst_done), 32'(e_done));
    check("addr_err",   32'(bus.addr_err),   32'(e_err));
`ifdef DSP_WRITE_ROUTER_ERRCNT_EN
    check("err_count",  32'(bus.err_count),  e_cnt);
`endif
  endtask

  // One clock: drive inputs, check registered outputs and wr_ready, advance model.
  task automatic cycle(input bit v, input int a, input logic [31:0] d, input bit bs,
                       input int ba, input int bl, input bit lk);
    bit ic, ok, rdy, acc;
    int idx, off, cur, n_err;
    @(posedge clk); #1;
    bus.wr_valid = v; bus.wr_addr = a[15:0]; bus.wr_data = d;
    bus.burst_start = bs; bus.burst_addr = ba[15:0]; bus.burst_len = bl[11:0];
    bus.cmd_lock = lk;
    @(negedge clk);
    check_outputs();
    cur = m_burst ? m_ptr : a;
    decode(cur, ic, ok, idx, off);
    rdy = !(!m_burst && bs) && !(ic && lk);
    check("wr_ready", 32'(bus.wr_ready), 32'(rdy));
    acc = v && rdy;
    e_cmd_we = '0; e_env_we = '0; e_done = 0;
    if (acc && ok) begin
      if (ic) begin e_cmd_we = 4'(1 << idx); e_cmd_waddr = off; e_cmd_wdata = d; end
      else    begin e_env_we = 3'(1 << idx); e_env_waddr = off; e_env_wdata = d; end
    end
    n_err = 0;
    if (acc && !ok)     n_err++;
    if (m_burst && bs)  n_err++;
    if (n_err > 0) begin
      e_err = 1;
      e_cnt = (e_cnt + n_err > 65535) ? 65535 : e_cnt + n_err;
    end
    if (!m_burst) begin
      if (bs) begin
        if (bl == 0) e_done = 1;
        else begin m_burst = 1; m_ptr = ba; m_rem = bl; end
      end
    end else if (acc) begin
      m_ptr = (m_ptr + 1) % 65536;
      m_rem = m_rem - 1;
      if (m_rem == 0) begin m_burst = 0; e_done = 1; end
    end
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    int ba_tab[6];
    int a, kind;
    ba_tab = '{32'h80FE, 32'hAFFE, 32'h03FE, 32'hFFFE, 32'h9FFD, 32'h0000};
    drive_idle();
    model_reset();

    // Reset state
    #12;
    check("rst_wr_ready", 32'(bus.wr_ready), 0);
    check_outputs();
    @(negedge clk); rst_n = 1'b1;

    // Single cmd beat, env beat to elem 2, out-of-range elem 3
    cycle(1, 32'h0205, 32'hDEADBEEF, 0, 0, 0, 0);
    cycle(1, 32'hA010, 32'h12345678, 0, 0, 0, 0);
    check("tp_cmd_we",    32'(bus.cmd_we),    32'h4);
    check("tp_cmd_waddr", 32'(bus.cmd_waddr), 32'h05);
    check("tp_cmd_wdata", bus.cmd_wdata,      32'hDEADBEEF);
    cycle(1, 32'hB000, 32'h0BADF00D, 0, 0, 0, 0);
    check("tp_env_we",    32'(bus.env_we),    32'h4);
    check("tp_env_waddr", 32'(bus.env_waddr), 32'h010);
    idle_cycle();
    check("tp_bad_elem_we", 32'(bus.env_we), 0);
    check("tp_addr_err",    32'(bus.addr_err), 1);

    // Lock stall with an env beat slipping through
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h0001, 32'hC0DE0000 + i, 0, 0, 0, 1);
      check("tp_lock_ready", 32'(bus.wr_ready), 0);
    end
    cycle(1, 32'h8000, 32'hE0E0E0E0, 0, 0, 0, 1);
    cycle(1, 32'h0001, 32'hC0DE0005, 0, 0, 0, 0);
    check("tp_lock_env_we", 32'(bus.env_we), 1);
    idle_cycle();
    check("tp_unlock_cmd_we", 32'(bus.cmd_we), 1);

    // Burst of 4 crossing an offset page inside elem 0
    cycle(0, 0, 0, 1, 32'h80FE, 4, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'h0400, 32'hB0000000 + i, 0, 0, 0, 0);
    idle_cycle();
    check("tp_burst_env_we",   32'(bus.env_we),     1);
    check("tp_burst_waddr",    32'(bus.env_waddr),  32'h101);
    check("tp_burst_done",     32'(bus.burst_done), 1);

    // Zero-length burst
    cycle(0, 0, 0, 1, 32'h8000, 0, 0);
    idle_cycle();
    check("tp_len0_done", 32'(bus.burst_done), 1);
    check("tp_len0_we",   32'(bus.env_we),     0);

    // burst_start inside a burst is ignored
    cycle(0, 0, 0, 1, 32'h9000, 3, 0);
    cycle(1, 0, 32'h11111111, 1, 32'h0000, 5, 0);
    cycle(1, 0, 32'h22222222, 0, 0, 0, 0);
    cycle(1, 0, 32'h33333333, 0, 0, 0, 0);
    idle_cycle();
    idle_cycle();

    // Reset mid-burst after 2 of 8 beats
    cycle(0, 0, 0, 1, 32'h8000, 8, 0);
    cycle(1, 0, 32'hAAAA0001, 0, 0, 0, 0);
    cycle(1, 0, 32'hAAAA0002, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_ready", 32'(bus.wr_ready), 0);
    check_outputs();
    drive_idle();
    @(negedge clk); rst_n = 1'b1;
    cycle(1, 32'h0000, 32'h5A5A5A5A, 0, 0, 0, 0);
    idle_cycle();
    check("post_rst_cmd_we", 32'(bus.cmd_we), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)      a = $urandom_range(0, 1023);
      else if (kind == 1) a = 32'h8000 + $urandom_range(0, 3 * 4096 - 1);
      else begin
        case ($urandom_range(0, 2))
          0:       a = 32'h0400 + $urandom_range(0, 32'h7BFF);
          1:       a = 32'hB000 + $urandom_range(0, 4095);
          default: a = 32'hC000 + $urandom_range(0, 32'h3FFF);
        endcase
      end
      cycle($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 24) == 0,
            ba_tab[$urandom_range(0, 5)], $urandom_range(0, 5), $urandom_range(0, 3) == 0);
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dsp_write_router.md
Name: dsp_write_router

Overview:
- Parametrised host-write front end for a multi-element DSP unit.
- Accepts a valid/ready write stream (single-beat or auto-incrementing burst).
- Decodes each beat into one of MEM_TO_CMD command-memory slices or one of N_ELEM element envelope memories, with one registered output stage.
- Stalls command writes while the processor holds the command memories locked; flags and drops writes to reserved or out-of-range addresses.

Parameters:
- ADDR_WIDTH, 16, host write address width; bit ADDR_WIDTH-1 is the space select (0 = cmd, 1 = env).
- DATA_WIDTH, 32, write data width.
- CMD_ADDR_WIDTH, 8, command buffer address width.
- MEM_TO_CMD, 4, command memory slices per command word (power of 2).
- N_ELEM, 3, number of elements, each with its own envelope memory (1..4).
- ENV_ADDR_WIDTH, 12, envelope memory address width.
- BURST_LEN_WIDTH, 12, burst length counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted when valid & ready
- wr_addr  in  ADDR_WIDTH  beat address (ignored in BURST)
- wr_data  in  DATA_WIDTH  beat data
- burst_start  in  1  pulse: begin burst
- burst_addr  in  ADDR_WIDTH  burst base address
- burst_len  in  BURST_LEN_WIDTH  burst beat count
- burst_done  out  1  one-cycle pulse at burst completion
- cmd_lock  in  1  high: command memories in use, stall cmd-space writes
- cmd_we  out  MEM_TO_CMD  one-hot command slice write enable
- cmd_waddr  out  CMD_ADDR_WIDTH  command buffer address
- cmd_wdata  out  DATA_WIDTH  command write data
- env_we  out  N_ELEM  one-hot envelope write enable
- env_waddr  out  ENV_ADDR_WIDTH  envelope address
- env_wdata  out  DATA_WIDTH  envelope write data
- addr_err  out  1  sticky: a beat was dropped as invalid

Behaviour:
- Reset: reset low asynchronously forces every output to 0, state to IDLE, and the burst counters to 0. This applies mid-burst as well; the in-flight output register is cleared.
- Address decode uses the current address A: wr_addr in IDLE, the internal pointer in BURST.
  - Cmd space (A[ADDR_WIDTH-1]=0):
    - slice = A[CMD_ADDR_WIDTH+log2(MEM_TO_CMD)-1 : CMD_ADDR_WIDTH]
    - offset = A[CMD_ADDR_WIDTH-1:0]
    - remaining bits below the select must be 0.
  - Env space (A[ADDR_WIDTH-1]=1):
    - elem = A[ENV_ADDR_WIDTH+1 : ENV_ADDR_WIDTH]
    - offset = A[ENV_ADDR_WIDTH-1:0]
    - elem must be < N_ELEM; bits above elem and below the select must be 0.
  - Any violation makes the beat invalid.
- wr_ready = 1 except in these cases:
  - reset asserted;
  - burst_start high this cycle in IDLE;
  - A decodes to cmd space and cmd_lock = 1 (the beat is stalled, not dropped).
- Invalid beats are accepted (wr_ready = 1) and dropped. addr_err is set and stays set until reset.
- Latency: an accepted valid beat in cycle N drives exactly one we bit, with address and data, in cycle N+1 for one cycle. Otherwise all we bits are 0. waddr and wdata hold their last values.
- FSM IDLE:
  - burst_start with burst_len > 0: load ptr = burst_addr and remaining = burst_len, go to BURST.
  - burst_start with burst_len = 0: pulse burst_done next cycle and stay in IDLE.
  - wr_valid without burst_start: single-beat mode.
- FSM BURST:
  - Each accepted beat writes at ptr; then ptr += 1 (wraps modulo 2^ADDR_WIDTH) and remaining -= 1.
  - The beat that makes remaining 0 returns the FSM to IDLE; burst_done pulses in the same cycle as that beat's we.
  - ptr crossing into a reserved region yields invalid beats (dropped, addr_err set). The count still decrements.
  - burst_start during BURST is ignored and sets addr_err.
- cmd_lock may change at any cycle. It affects only wr_ready for the current beat; an output already registered is still issued.

Optional Feature:
- Macro DSP_WRITE_ROUTER_ERRCNT_EN.
- When defined: adds output err_count (16 bits), incremented once per dropped beat and once per ignored burst_start. It saturates at 0xFFFF and is cleared by reset.
- When undefined: the port and counter are absent; addr_err behaviour is unchanged.

Test Plan:
- Single cmd beat: wr_addr=0x0205, wr_data=0xDEADBEEF, cmd_lock=0 -> next cycle cmd_we=4'b0100, cmd_waddr=0x05, cmd_wdata=0xDEADBEEF; env_we=0.
- Env beat to elem 2: wr_addr=0xA010 -> next cycle env_we=3'b100, env_waddr=0x010. Then wr_addr=0xB000 (elem 3 ≥ N_ELEM) -> no we, addr_err=1.
- Lock stall: cmd_lock=1, wr_addr=0x0001 valid for 5 cycles -> wr_ready=0 and no cmd_we. Meanwhile an env beat to 0x8000 is accepted. Releasing the lock -> cmd beat issues one cycle after acceptance.
- Burst: burst_addr=0x80FE, burst_len=4, four data beats -> env_we[0] at env_waddr 0x0FE, 0x0FF, 0x100, 0x101. burst_done pulses with the fourth we; FSM returns to IDLE.
- Edge cases:
  - burst_len=0 -> burst_done one cycle after burst_start, no writes.
  - burst_start during a burst -> ignored, addr_err=1, err_count+1 with DSP_WRITE_ROUTER_ERRCNT_EN.
- Reset mid-burst after 2 of 8 beats -> all outputs 0 immediately; after release, a single beat to wr_addr=0x0000 writes cmd slice 0 normally.
